// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM state type, accumulator sizing and the scale/saturate
// helper used by the streaming convolution blocks.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } conv_state_e;

    // Wide enough for any accumulator plus a pre-scaled bias at supported sizes.
    typedef logic signed [127:0] wide_t;

    // Accumulator width for K*K products of two N-bit signed operands.
    function automatic int ACC_W(input int n, input int k);
        return 2 * n + $clog2(k * k);
    endfunction

    // Arithmetic shift right by q (floor toward -inf), clamp to signed n-bit range.
    function automatic wide_t sat_shift(input wide_t acc, input int q, input int n);
        wide_t shifted;
        wide_t max_v;
        wide_t min_v;
        shifted = acc >>> q;
        max_v   = (wide_t'(1) <<< (n - 1)) - wide_t'(1);
        min_v   = -(wide_t'(1) <<< (n - 1));
        if (shifted > max_v) begin
            return max_v;
        end
        if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-entry shift register holding one image row; dout is the
// entry written DEPTH shifts ago (same column, previous row).
module line_buffer #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         shift_en,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    logic [N-1:0] mem_q [DEPTH];
    logic [N-1:0] mem_d [DEPTH];

    // Next contents: move every entry one place toward the tail on shift.
    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            mem_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Storage register; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK 2D convolver with stride, per-frame bias,
// saturation and valid/ready on both sides.
// Optional: define CONV2D_RELU_EN to clamp negative results to zero.
module conv2d_stream
    import cnn_pkg::*;
#(
    parameter int N     = 16,
    parameter int Q     = 12,
    parameter int IMG_N = 4,
    parameter int K     = 3,
    parameter int S     = 1
) (
    input  logic             clk,
    input  logic             global_rst,
    input  logic             start,
    input  logic [K*K*N-1:0] weight,
    input  logic [N-1:0]     bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     activation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     conv_op,
    output logic             busy,
    output logic             end_conv
);

    localparam int AW   = ACC_W(N, K);
    localparam int RC_W = (IMG_N > 1) ? $clog2(IMG_N) : 1;

    conv_state_e        state_q, state_d;
    logic [K*K*N-1:0]   weight_q, weight_d;
    logic [N-1:0]       bias_q, bias_d;
    logic [RC_W-1:0]    row_q, row_d, col_q, col_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       conv_op_q, conv_op_d;
    logic [N-1:0]       win_q [K][K];
    logic [N-1:0]       win_d [K][K];
    logic [N-1:0]       tap [K];
    logic               accept, emit, last_pix;
    logic signed [2*N-1:0] prod;
    logic signed [AW-1:0]  acc;
    wide_t              sat;
    logic [N-1:0]       result;

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign conv_op   = conv_op_q;
    assign busy      = (state_q != IDLE);
    assign end_conv  = (state_q == DONE);

    assign last_pix = (row_q == RC_W'(IMG_N - 1)) && (col_q == RC_W'(IMG_N - 1));
    assign emit     = (32'(row_q) >= 32'(K - 1)) && (32'(col_q) >= 32'(K - 1))
                   && (((32'(row_q) - 32'(K - 1)) % 32'(S)) == 32'd0)
                   && (((32'(col_q) - 32'(K - 1)) % 32'(S)) == 32'd0);

    // Window column: newest row straight from the input, older rows from the chain.
    assign tap[K-1] = activation;
    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        line_buffer #(
            .N    (N),
            .DEPTH(IMG_N)
        ) u_lb (
            .clk     (clk),
            .shift_en(accept),
            .din     (tap[K-1-g]),
            .dout    (tap[K-2-g])
        );
    end

    // Window after an accept: shift columns left, load the new column on the right.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c + 1 < K; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = tap[r];
            end
        end
    end

    // Window register; shifts only on accept, no reset needed.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    // MAC over the updated window, then bias, scale and saturate.
    // Bias is pre-shifted into the accumulator: floor((a + b*2^Q)/2^Q) == floor(a/2^Q) + b.
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                prod = $signed(win_d[r][c]) * $signed(weight_q[(r*K+c)*N +: N]);
                acc  = acc + AW'(prod);
            end
        end
        sat    = sat_shift(wide_t'(acc) + (wide_t'($signed(bias_q)) <<< Q), Q, N);
        result = N'(sat);
`ifdef CONV2D_RELU_EN
        if (result[N-1]) begin
            result = '0;
        end
`endif
    end

    // Next-state, raster counters, parameter latch and output register update.
    always_comb begin
        state_d     = state_q;
        weight_d    = weight_q;
        bias_d      = bias_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        conv_op_d   = conv_op_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && emit) begin
            out_valid_d = 1'b1;
            conv_op_d   = result;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    weight_d = weight;
                    bias_d   = bias;
                    row_d    = '0;
                    col_d    = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == RC_W'(IMG_N - 1)) begin
                        col_d = '0;
                        row_d = row_q + RC_W'(1);
                    end else begin
                        col_d = col_q + RC_W'(1);
                    end
                    if (last_pix) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q     <= IDLE;
            weight_q    <= '0;
            bias_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            conv_op_q   <= '0;
        end else begin
            state_q     <= state_d;
            weight_q    <= weight_d;
            bias_q      <= bias_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            conv_op_q   <= conv_op_d;
        end
    end

endmodule
